fetch_buffer: RTL and testbench

Parametrised F-stage successor with a prefetch queue: fetches one instruction per cycle from a combinational instruction memory and buffers up to DEPTH entries of {instruction, PC+4}. It hands them to the F/D pipeline register (IRD/PC4D) on every non-stalled cycle. Branch/jump redirects from D flush the queue while preserving the MIPS delay slot. It replaces the unbuffered F stage between the IM and the D stage.

---
 rtl/fetch_buffer.sv | 130 +++++++++++++
 tb/tb_fetch_buffer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_buffer.sv
// Fetch stage with a DEPTH-entry prefetch queue of {instruction, PC+4} feeding IRD/PC4D.
// Define FETCH_BYPASS_EN to forward ImemData straight into IRD when the queue is empty.
module fetch_buffer #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter int unsigned IM_AW    = 10
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic                     StallD,
   input  logic                     Redirect,
   input  logic [31:0]              RedirectPC,
   output logic [IM_AW-1:0]         ImemAddr,
   input  logic [31:0]              ImemData,
   output logic [31:0]              IRD,
   output logic [31:0]              PC4D,
   output logic [$clog2(DEPTH):0]   Count,
   output logic                     Full,
   output logic                     Empty
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [31:0]    pc;
   logic [31:0]    pc_plus4;
   logic [PW-1:0]  head;
   logic [PW-1:0]  tail;
   logic [31:0]    q_instr [DEPTH];
   logic [31:0]    q_pc4   [DEPTH];

   logic           do_push;
   logic           do_pop;
   logic           flush;
   logic [31:0]    pc_n;
   logic [31:0]    ird_n;
   logic [31:0]    pc4d_n;
   logic [PW-1:0]  head_n;
   logic [PW-1:0]  tail_n;
   logic [CW-1:0]  count_n;

   assign pc_plus4 = pc + 32'd4;
   assign ImemAddr = pc[IM_AW+1:2];

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      do_push = 1'b0;
      do_pop  = 1'b0;
      flush   = 1'b0;
      pc_n    = pc;
      ird_n   = IRD;
      pc4d_n  = PC4D;
      if (Redirect && !StallD) begin
         // The delay slot is the head entry if one exists, else the word fetched this cycle.
         pc_n = RedirectPC;
         if (!Empty) begin
            ird_n  = q_instr[head];
            pc4d_n = q_pc4[head];
            flush  = 1'b1;
         end else begin
`ifdef FETCH_BYPASS_EN
            ird_n  = ImemData;
            pc4d_n = pc_plus4;
`else
            ird_n   = '0;
            pc4d_n  = '0;
            do_push = 1'b1;
`endif
         end
      end else if (!StallD) begin
         pc_n = pc_plus4;
         if (!Empty) begin
            ird_n   = q_instr[head];
            pc4d_n  = q_pc4[head];
            do_pop  = 1'b1;
            do_push = 1'b1;
         end else begin
`ifdef FETCH_BYPASS_EN
            ird_n  = ImemData;
            pc4d_n = pc_plus4;
`else
            ird_n   = '0;
            pc4d_n  = '0;
            do_push = 1'b1;
`endif
         end
      end else if (!Full) begin
         do_push = 1'b1;
         pc_n    = pc_plus4;
      end
   end

   always_comb begin
      tail_n  = do_push ? tail + PW'(1) : tail;
      head_n  = flush ? tail : (do_pop ? head + PW'(1) : head);
      count_n = flush ? '0 : Count + CW'(do_push) - CW'(do_pop);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         pc    <= RESET_PC;
         head  <= '0;
         tail  <= '0;
         Count <= '0;
         Full  <= 1'b0;
         Empty <= 1'b1;
         IRD   <= '0;
         PC4D  <= '0;
      end else begin
         pc    <= pc_n;
         head  <= head_n;
         tail  <= tail_n;
         Count <= count_n;
         Full  <= (count_n == CW'(DEPTH));
         Empty <= (count_n == '0);
         IRD   <= ird_n;
         PC4D  <= pc4d_n;
      end
   end

   // NOTE: queue storage has no reset; Count/Empty guarantee stale entries are never read.
   always_ff @(posedge Clk) begin
      if (do_push) begin
         q_instr[tail] <= ImemData;
         q_pc4[tail]   <= pc_plus4;
      end
   end

endmodule

// File: tb/tb_fetch_buffer.sv
// Scoreboard bench for fetch_buffer: stimulus queues expected IRD/PC4D, a monitor checks each load.
module tb_fetch_buffer;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned IM_AW = 12;
   localparam int unsigned CW    = $clog2(DEPTH) + 1;

`ifdef FETCH_BYPASS_EN
   localparam int A_CNT  = 0;
   localparam int E_CNT  = 3;
   localparam int E_ADDR = 'hC44;
   localparam int D_CNT  = 0;
   localparam int D_ADDR = 'hC81;
`else
   localparam int A_CNT  = 1;
   localparam int E_CNT  = 4;
   localparam int E_ADDR = 'hC45;
   localparam int D_CNT  = 1;
   localparam int D_ADDR = 'hC82;
`endif

   logic             Clk = 1'b0;
   logic             Reset;
   logic             StallD;
   logic             Redirect;
   logic [31:0]      RedirectPC;
   logic [IM_AW-1:0] ImemAddr;
   logic [31:0]      ImemData;
   logic [31:0]      IRD;
   logic [31:0]      PC4D;
   logic [CW-1:0]    Count;
   logic             Full;
   logic             Empty;

   typedef struct packed {
      logic [31:0] ird;
      logic [31:0] pc4d;
   } fd_exp_t;

   fd_exp_t sb[$];
   int      checks = 0;
   int      errors = 0;

   fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h0000_3000), .IM_AW(IM_AW)) dut (
      .Clk(Clk), .Reset(Reset), .StallD(StallD), .Redirect(Redirect),
      .RedirectPC(RedirectPC), .ImemAddr(ImemAddr), .ImemData(ImemData),
      .IRD(IRD), .PC4D(PC4D), .Count(Count), .Full(Full), .Empty(Empty)
   );

   always #5 Clk = ~Clk;

   // Instruction memory: each word encodes its own byte address.
   assign ImemData = 32'hAB00_0000 | {18'b0, ImemAddr, 2'b00};

   function automatic logic [31:0] w(input logic [31:0] pc);
      return 32'hAB00_0000 | (pc & 32'h0000_3FFC);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic expect_fd(input logic [31:0] ird, input logic [31:0] pc4d);
      sb.push_back('{ird: ird, pc4d: pc4d});
   endtask

   task automatic cyc(input logic s, input logic r, input logic [31:0] rpc);
      StallD     = s;
      Redirect   = r;
      RedirectPC = rpc;
      @(posedge Clk);
      #1;
   endtask

   task automatic do_reset(input logic r);
      Reset = 1'b1;
      cyc(1'b0, r, 32'h0000_3300);
      Reset = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_ird"},   IRD,   32'h0);
      check({tag, "_pc4d"},  PC4D,  32'h0);
      check({tag, "_count"}, Count, 32'h0);
      check({tag, "_empty"}, Empty, 32'h1);
      check({tag, "_full"},  Full,  32'h0);
      check({tag, "_addr"},  ImemAddr, 32'hC00);
   endtask

   // Monitor: every non-reset, non-stalled edge loads IRD/PC4D.
   initial begin
      logic ld;
      forever begin
         @(posedge Clk);
         ld = !Reset && !StallD;
         @(negedge Clk);
         if (ld) begin
            if (sb.size() == 0) begin
               check("sb_underflow", 32'h1, 32'h0);
            end else begin
               fd_exp_t e;
               e = sb.pop_front();
               check("ird",  IRD,  e.ird);
               check("pc4d", PC4D, e.pc4d);
            end
         end
      end
   end

   initial begin
      Reset = 1'b1; StallD = 1'b0; Redirect = 1'b0; RedirectPC = '0;
      cyc(1'b0, 1'b0, 32'h0);
      cyc(1'b0, 1'b0, 32'h0);
      Reset = 1'b0;
      check_reset_state("rst0");

      // Sequential fetch after reset release.
`ifdef FETCH_BYPASS_EN
      expect_fd(w(32'h3000), 32'h3004);
      expect_fd(w(32'h3004), 32'h3008);
      expect_fd(w(32'h3008), 32'h300C);
`else
      expect_fd(32'h0, 32'h0);
      expect_fd(w(32'h3000), 32'h3004);
      expect_fd(w(32'h3004), 32'h3008);
`endif
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 32'h0);
      check("seq_count", Count, A_CNT);
      check("seq_addr",  ImemAddr, 32'hC03);

      // Fill under stall, then drain with simultaneous pop/push at Full.
      do_reset(1'b0);
      for (int i = 0; i < 6; i++) begin
         cyc(1'b1, 1'b0, 32'h0);
         check("fill_count", Count, (i < 3) ? i + 1 : 4);
         check("fill_full",  Full,  (i >= 3) ? 1 : 0);
      end
      check("fill_addr", ImemAddr, 32'hC04);
      check("fill_ird",  IRD, 32'h0);
      for (int i = 0; i < 4; i++) begin
         expect_fd(w(32'h3000 + 4 * i), 32'h3004 + 4 * i);
         cyc(1'b0, 1'b0, 32'h0);
      end
      check("drain_count", Count, 32'd4);
      check("drain_full",  Full,  32'h1);
      check("drain_addr",  ImemAddr, 32'hC08);

      // Redirect with Count=3: head is the delay slot, rest flushed.
      do_reset(1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'h0);
      check("pre_redir_count", Count, 32'd3);
      expect_fd(w(32'h3000), 32'h3004);
      cyc(1'b0, 1'b1, 32'h3100);
      check("redir_count", Count, 32'h0);
      check("redir_empty", Empty, 32'h1);
      check("redir_addr",  ImemAddr, 32'hC40);
`ifndef FETCH_BYPASS_EN
      expect_fd(32'h0, 32'h0);
      cyc(1'b0, 1'b0, 32'h0);
`endif
      expect_fd(w(32'h3100), 32'h3104);
      cyc(1'b0, 1'b0, 32'h0);

      // Redirect while stalled is ignored; then reset beats a concurrent redirect.
      cyc(1'b1, 1'b0, 32'h0);
      cyc(1'b1, 1'b0, 32'h0);
      cyc(1'b1, 1'b1, 32'h3300);
      check("stall_redir_count", Count, E_CNT);
      check("stall_redir_addr",  ImemAddr, E_ADDR);
      check("stall_redir_ird",   IRD, w(32'h3100));
      do_reset(1'b1);
      check_reset_state("rst1");

      // Redirect with Count=0 right after reset.
`ifdef FETCH_BYPASS_EN
      expect_fd(w(32'h3000), 32'h3004);
      cyc(1'b0, 1'b1, 32'h3200);
`else
      expect_fd(32'h0, 32'h0);
      cyc(1'b0, 1'b1, 32'h3200);
      expect_fd(w(32'h3000), 32'h3004);
      cyc(1'b0, 1'b0, 32'h0);
`endif
      expect_fd(w(32'h3200), 32'h3204);
      cyc(1'b0, 1'b0, 32'h0);
      check("redir0_count", Count, D_CNT);
      check("redir0_addr",  ImemAddr, D_ADDR);

      @(negedge Clk);
      #1;
      check("sb_drain", sb.size(), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
